// File: rtl/condlogic_pkg.sv
// Shared constants for the conditional-execution unit: condition codes,
// NZCV flag bit positions and FlagW request bit positions.
package condlogic_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// condcheck: purely combinational evaluation of the 4-bit condition field
// against the current NZCV flags.
module condcheck
  import condlogic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondPass
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondPass = 1'b0;
    unique case (Cond)
      COND_EQ: CondPass = z;
      COND_NE: CondPass = !z;
      COND_CS: CondPass = c;
      COND_CC: CondPass = !c;
      COND_MI: CondPass = n;
      COND_PL: CondPass = !n;
      COND_VS: CondPass = v;
      COND_VC: CondPass = !v;
      COND_HI: CondPass = c && !z;
      COND_LS: CondPass = !c || z;
      COND_GE: CondPass = (n == v);
      COND_LT: CondPass = (n != v);
      COND_GT: CondPass = !z && (n == v);
      COND_LE: CondPass = z || (n != v);
      COND_AL: CondPass = 1'b1;
      COND_NV: CondPass = 1'b0;  // never-execute, no trap
      default: CondPass = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// condlogic: NZCV flag register, latched condition result and write-strobe gating.
// Optional macro CONDLOGIC_SHADOW_EN adds a shadow flag register with save/restore.
module condlogic
  import condlogic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       LatchCond,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
`ifdef CONDLOGIC_SHADOW_EN
  input  logic       FlagSave,
  input  logic       FlagRestore,
`endif
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic       cond_pass;
  logic [3:0] flags_next;

  condcheck u_condcheck (
    .Cond     (Cond),
    .Flags    (Flags),
    .CondPass (cond_pass)
  );

`ifdef CONDLOGIC_SHADOW_EN
  logic [3:0] shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow <= 4'b0000;
    else if (FlagSave) shadow <= Flags;
  end
`endif

  // Flag write gate uses the pre-edge CondEx, so a same-edge re-latch has no effect on it.
  always_comb begin
    flags_next = Flags;
    if (FlagW[FLAGW_NZ] && CondEx)
      flags_next[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    if (FlagW[FLAGW_CV] && CondEx)
      flags_next[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
`ifdef CONDLOGIC_SHADOW_EN
    if (FlagRestore) flags_next = shadow;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags  <= 4'b0000;
      CondEx <= 1'b0;
    end else begin
      Flags <= flags_next;
      if (LatchCond) CondEx <= cond_pass;
    end
  end

  assign PCWrite  = (PCS && CondEx) || NextPC;
  assign RegWrite = RegW && CondEx;
  assign MemWrite = MemW && CondEx;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic; covers the shadow-flag feature when
// CONDLOGIC_SHADOW_EN is defined.
module tb_condlogic;
  import condlogic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       LatchCond, PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef CONDLOGIC_SHADOW_EN
  logic       FlagSave, FlagRestore;
`endif

  condlogic dut (
    .clk         (clk),
    .reset       (reset),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .LatchCond   (LatchCond),
    .PCS         (PCS),
    .NextPC      (NextPC),
    .RegW        (RegW),
    .MemW        (MemW),
`ifdef CONDLOGIC_SHADOW_EN
    .FlagSave    (FlagSave),
    .FlagRestore (FlagRestore),
`endif
    .PCWrite     (PCWrite),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .Flags       (Flags),
    .CondEx      (CondEx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       latch, pcs, nextpc, regw, memw;
  } stim_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];
  logic [3:0] m_flags, m_shadow;
  logic       m_cex;

  function automatic stim_t pk(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] flagw,
                               input logic latch, input logic pcs, input logic nextpc,
                               input logic regw, input logic memw);
    stim_t s;
    s.cond = cond; s.alu = alu; s.flagw = flagw; s.latch = latch;
    s.pcs = pcs; s.nextpc = nextpc; s.regw = regw; s.memw = memw;
    return s;
  endfunction

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy & !z;
      4'd9:  return !cy | z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z & (n == v);
      4'd13: return z | (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] expect_obs(input stim_t s);
    return {m_flags, m_cex, (s.pcs & m_cex) | s.nextpc, s.regw & m_cex, s.memw & m_cex};
  endfunction

  function automatic logic [7:0] obs();
    return {Flags, CondEx, PCWrite, RegWrite, MemWrite};
  endfunction

  // Drive one instruction cycle, advance the model, queue the expected post-edge view.
  task automatic drive_cycle(input stim_t s, input logic save, input logic restore);
    logic       pass;
    logic [3:0] nf;
    Cond = s.cond; ALUFlags = s.alu; FlagW = s.flagw; LatchCond = s.latch;
    PCS = s.pcs; NextPC = s.nextpc; RegW = s.regw; MemW = s.memw;
`ifdef CONDLOGIC_SHADOW_EN
    FlagSave = save; FlagRestore = restore;
`endif
    pass = cond_eval(s.cond, m_flags);
    nf = m_flags;
    if (s.flagw[1] & m_cex) nf[3:2] = s.alu[3:2];
    if (s.flagw[0] & m_cex) nf[1:0] = s.alu[1:0];
    if (restore) nf = m_shadow;
    if (save) m_shadow = m_flags;
    m_flags = nf;
    if (s.latch) m_cex = pass;
    sb.push_back(expect_obs(s));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    stim_t s;
    s = pk(COND_AL, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    s.pcs = 1'b0; s.memw = 1'b0;
    reset = 1'b0;
    Cond = s.cond; ALUFlags = s.alu; FlagW = s.flagw; LatchCond = s.latch;
    PCS = s.pcs; NextPC = s.nextpc; RegW = s.regw; MemW = s.memw;
`ifdef CONDLOGIC_SHADOW_EN
    FlagSave = 1'b0; FlagRestore = 1'b0;
`endif
    m_flags = 4'b0000; m_cex = 1'b0; m_shadow = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(expect_obs(s));
      @(negedge clk);
      got = obs(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", i, got, exp);
      end
    end
    FlagW = 2'b00; LatchCond = 1'b0; NextPC = 1'b0; RegW = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    stim_t s[5];
    logic [7:0] got, exp;
    s[0] = pk(COND_AL, 4'h0,    2'b00, 1, 0, 0, 0, 0);
    s[1] = pk(COND_AL, 4'b0110, 2'b11, 0, 0, 0, 0, 0);
    s[2] = pk(COND_EQ, 4'h0,    2'b00, 1, 0, 0, 1, 0);
    s[3] = pk(COND_NE, 4'h0,    2'b00, 1, 0, 0, 1, 0);
    s[4] = pk(COND_NE, 4'h0,    2'b00, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(s[i], 1'b0, 1'b0);
      got = obs(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL basic[%0d]: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", i, got, exp);
      end
    end
  endtask

  // Every condition code against several flag patterns.
  task automatic test_conditions();
    logic [3:0] fpat[5];
    logic [7:0] got, exp;
    fpat[0] = 4'b1000; fpat[1] = 4'b0010; fpat[2] = 4'b0101;
    fpat[3] = 4'b1001; fpat[4] = 4'b0110;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive_cycle(pk(COND_AL, 4'h0, 2'b00, 1, 0, 0, 0, 0), 1'b0, 1'b0);
        void'(sb.pop_front());
        drive_cycle(pk(COND_AL, fpat[f], 2'b11, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        void'(sb.pop_front());
        drive_cycle(pk(4'(c), 4'h0, 2'b00, 1, 1, 0, 1, 1), 1'b0, 1'b0);
        got = obs(); exp = sb.pop_front(); n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL cond flags=%b cond=%0d: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b",
                   fpat[f], c, got, exp);
        end
      end
    end
  endtask

  task automatic test_flag_halves();
    stim_t s[6];
    logic [7:0] got, exp;
    s[0] = pk(COND_AL, 4'h0,    2'b00, 1, 0, 0, 0, 0);
    s[1] = pk(COND_AL, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    s[2] = pk(COND_AL, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
    s[3] = pk(COND_AL, 4'b0011, 2'b01, 0, 0, 0, 0, 0);
    s[4] = pk(COND_NV, 4'h0,    2'b00, 1, 0, 1, 0, 0);
    s[5] = pk(COND_NV, 4'b0000, 2'b11, 0, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(s[i], 1'b0, 1'b0);
      got = obs(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flag_halves[%0d]: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", i, got, exp);
      end
    end
  endtask

  // Latch and flag write on the same edge, then re-latch with a gated flag write.
  task automatic test_same_edge();
    stim_t s[4];
    logic [7:0] got, exp;
    s[0] = pk(COND_AL, 4'h0,    2'b00, 1, 0, 0, 0, 0);
    s[1] = pk(COND_AL, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    s[2] = pk(COND_EQ, 4'b0100, 2'b11, 1, 1, 0, 0, 0);
    s[3] = pk(COND_EQ, 4'b0000, 2'b11, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(s[i], 1'b0, 1'b0);
      got = obs(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL same_edge[%0d]: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic save, restore;
    logic [7:0] got, exp;
    for (int i = 0; i < 200; i++) begin
      s = pk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      save = 1'b0; restore = 1'b0;
`ifdef CONDLOGIC_SHADOW_EN
      save = ($urandom_range(0, 3) == 0);
      restore = ($urandom_range(0, 3) == 0);
`endif
      drive_cycle(s, save, restore);
      got = obs(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    logic [7:0] got, exp;
    drive_cycle(pk(COND_AL, 4'h0, 2'b00, 1, 0, 0, 0, 0), 1'b0, 1'b0);
    void'(sb.pop_front());
    drive_cycle(pk(COND_AL, 4'b1011, 2'b11, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    void'(sb.pop_front());
    s = pk(COND_AL, 4'h0, 2'b00, 0, 1, 0, 1, 1);
    drive_cycle(s, 1'b0, 1'b0);
    got = obs(); exp = sb.pop_front(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid before: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", got, exp);
    end
    reset = 1'b0;
    m_flags = 4'b0000; m_cex = 1'b0; m_shadow = 4'b0000;
    sb.push_back(expect_obs(s));
    #1;
    got = obs(); exp = sb.pop_front(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid async: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", got, exp);
    end
    #2;
    reset = 1'b1;
  endtask

`ifdef CONDLOGIC_SHADOW_EN
  task automatic test_shadow();
    stim_t s[7];
    logic sv[7], rs[7];
    logic [7:0] got, exp;
    s[0] = pk(COND_AL, 4'h0,    2'b00, 1, 0, 0, 0, 0); sv[0] = 0; rs[0] = 0;
    s[1] = pk(COND_AL, 4'b1010, 2'b11, 0, 0, 0, 0, 0); sv[1] = 0; rs[1] = 0;
    s[2] = pk(COND_AL, 4'h0,    2'b00, 0, 0, 0, 0, 0); sv[2] = 1; rs[2] = 0;
    s[3] = pk(COND_AL, 4'b0101, 2'b11, 0, 0, 0, 0, 0); sv[3] = 0; rs[3] = 0;
    s[4] = pk(COND_AL, 4'b1111, 2'b11, 0, 0, 0, 0, 0); sv[4] = 0; rs[4] = 1;
    s[5] = pk(COND_AL, 4'b0011, 2'b11, 0, 0, 0, 0, 0); sv[5] = 0; rs[5] = 0;
    s[6] = pk(COND_AL, 4'h0,    2'b00, 0, 0, 0, 0, 0); sv[6] = 1; rs[6] = 1;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(s[i], sv[i], rs[i]);
      got = obs(); exp = sb.pop_front(); n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL shadow[%0d]: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", i, got, exp);
      end
    end
    // After the swap the shadow holds 0011; restoring brings it back.
    drive_cycle(pk(COND_AL, 4'h0, 2'b00, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    got = obs(); exp = sb.pop_front(); n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL shadow swap restore: {Flags,CondEx,PCWrite,RegWrite,MemWrite} got %b expected %b", got, exp);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_conditions();
    test_flag_halves();
    test_same_edge();
    test_reset_mid();
`ifdef CONDLOGIC_SHADOW_EN
    test_shadow();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
